// File: rtl/l2_cache_arb_rr_if.sv
// ----------------------------------------------------------------------------
// l2_cache_arb_rr_if
//
// Bundle of every non-clock, non-reset signal of the L2 pipeline arbitration
// stage: the per-port core request bus, the SMI restart/fill request, the
// downstream stall and the registered stage-1 request.
//
// Modports:
//   master - the surrounding pipeline (drives requests, observes grants and
//            the registered stage-1 request)
//   slave  - the arbiter itself
//
// Per-port fields are packed: port i of a W-bit field occupies
// bits [W*i +: W].
// ----------------------------------------------------------------------------
interface l2_cache_arb_rr_if #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned PORT_IDX_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned MASK_WIDTH     = 64
);

  // Downstream stall
  logic                             stall_pipeline;

  // Core request ports
  logic [NUM_PORTS-1:0]             l2req_valid;
  logic [NUM_PORTS-1:0]             l2req_ready;
  logic [2*NUM_PORTS-1:0]           l2req_unit;
  logic [2*NUM_PORTS-1:0]           l2req_strand;
  logic [3*NUM_PORTS-1:0]           l2req_op;
  logic [2*NUM_PORTS-1:0]           l2req_way;
  logic [ADDR_WIDTH*NUM_PORTS-1:0]  l2req_address;
  logic [DATA_WIDTH*NUM_PORTS-1:0]  l2req_data;
  logic [MASK_WIDTH*NUM_PORTS-1:0]  l2req_mask;

  // SMI restart request
  logic                             smi_input_wait;
  logic                             smi_data_ready;
  logic                             smi_data_accept;
  logic [1:0]                       smi_l2req_unit;
  logic [1:0]                       smi_l2req_strand;
  logic [2:0]                       smi_l2req_op;
  logic [1:0]                       smi_l2req_way;
  logic [ADDR_WIDTH-1:0]            smi_l2req_address;
  logic [DATA_WIDTH-1:0]            smi_l2req_data;
  logic [MASK_WIDTH-1:0]            smi_l2req_mask;
  logic [DATA_WIDTH-1:0]            smi_load_buffer_vec;
  logic [1:0]                       smi_fill_l2_way;
  logic                             smi_duplicate_request;

  // Registered stage-1 request
  logic                             arb_l2req_valid;
  logic [PORT_IDX_WIDTH-1:0]        arb_l2req_port;
  logic [1:0]                       arb_l2req_unit;
  logic [1:0]                       arb_l2req_strand;
  logic [2:0]                       arb_l2req_op;
  logic [1:0]                       arb_l2req_way;
  logic [ADDR_WIDTH-1:0]            arb_l2req_address;
  logic [DATA_WIDTH-1:0]            arb_l2req_data;
  logic [MASK_WIDTH-1:0]            arb_l2req_mask;
  logic                             arb_has_sm_data;
  logic [DATA_WIDTH-1:0]            arb_sm_data;
  logic [1:0]                       arb_sm_fill_l2_way;

  modport master (
    output stall_pipeline,
    output l2req_valid, l2req_unit, l2req_strand, l2req_op, l2req_way,
    output l2req_address, l2req_data, l2req_mask,
    input  l2req_ready,
    output smi_input_wait, smi_data_ready,
    output smi_l2req_unit, smi_l2req_strand, smi_l2req_op, smi_l2req_way,
    output smi_l2req_address, smi_l2req_data, smi_l2req_mask,
    output smi_load_buffer_vec, smi_fill_l2_way, smi_duplicate_request,
    input  smi_data_accept,
    input  arb_l2req_valid, arb_l2req_port, arb_l2req_unit, arb_l2req_strand,
    input  arb_l2req_op, arb_l2req_way, arb_l2req_address, arb_l2req_data,
    input  arb_l2req_mask, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way
  );

  modport slave (
    input  stall_pipeline,
    input  l2req_valid, l2req_unit, l2req_strand, l2req_op, l2req_way,
    input  l2req_address, l2req_data, l2req_mask,
    output l2req_ready,
    input  smi_input_wait, smi_data_ready,
    input  smi_l2req_unit, smi_l2req_strand, smi_l2req_op, smi_l2req_way,
    input  smi_l2req_address, smi_l2req_data, smi_l2req_mask,
    input  smi_load_buffer_vec, smi_fill_l2_way, smi_duplicate_request,
    output smi_data_accept,
    output arb_l2req_valid, arb_l2req_port, arb_l2req_unit, arb_l2req_strand,
    output arb_l2req_op, arb_l2req_way, arb_l2req_address, arb_l2req_data,
    output arb_l2req_mask, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way
  );

endinterface

// File: rtl/l2_cache_arb_rr.sv
// ----------------------------------------------------------------------------
// l2_cache_arb_rr
//
// L2 pipeline arbitration stage. Each cycle picks at most one of:
//   - the restarted request from the SMI queue (normally highest priority), or
//   - one of NUM_PORTS core request ports, chosen round-robin,
// and registers the winner into the first L2 pipeline stage.
//
// A starvation counter tracks consecutive SMI wins that blocked an eligible
// core. Once it reaches STARVE_LIMIT the next eligible core request is forced
// through ahead of SMI (STARVE_LIMIT = 0 disables this).
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset (priority over stall)
//   bus    - l2_cache_arb_rr_if.slave: core ports, SMI request, stall and the
//            registered stage-1 request
//
// Grants (l2req_ready, smi_data_accept) are combinational and mutually
// exclusive; the stage-1 request appears one cycle after its grant.
// ----------------------------------------------------------------------------
module l2_cache_arb_rr #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned PORT_IDX_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned MASK_WIDTH     = 64,
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned CNT_WIDTH      = 4
) (
  input logic             clk,
  input logic             reset,
  l2_cache_arb_rr_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]      StarveMax = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [PORT_IDX_WIDTH-1:0] LastPort  = PORT_IDX_WIDTH'(NUM_PORTS - 1);

  // Arbitration state
  logic [PORT_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]      starve_cnt_q, starve_cnt_d;

  // Registered stage-1 request
  logic                      valid_q;
  logic [PORT_IDX_WIDTH-1:0] port_q;
  logic [1:0]                unit_q, strand_q, way_q;
  logic [2:0]                op_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [MASK_WIDTH-1:0]     mask_q;
  logic                      has_sm_q;
  logic [DATA_WIDTH-1:0]     sm_data_q;
  logic [1:0]                fill_way_q;

  // Decision
  logic                      core_ok;
  logic                      force_core;
  logic                      smi_win;
  logic                      core_win;
  logic [PORT_IDX_WIDTH-1:0] sel;

  // Selected core fields
  logic [1:0]                core_unit, core_strand, core_way;
  logic [2:0]                core_op;
  logic [ADDR_WIDTH-1:0]     core_addr;
  logic [DATA_WIDTH-1:0]     core_data;
  logic [MASK_WIDTH-1:0]     core_mask;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  assign core_ok    = !bus.stall_pipeline && !bus.smi_input_wait && (|bus.l2req_valid);
  assign force_core = (STARVE_LIMIT != 0) && (starve_cnt_q == StarveMax);

  // Reset gates the grants so nothing is consumed while the stage is being cleared.
  assign smi_win  = !reset && !bus.stall_pipeline && bus.smi_data_ready &&
                    !(force_core && core_ok);
  assign core_win = !reset && !smi_win && core_ok;

  // Round-robin: lowest valid port at or above rr_ptr, else lowest valid port
  // overall (the wrap-around case). Scanning downwards leaves the lowest
  // matching index in each candidate.
  always_comb begin
    logic                      found_hi;
    logic [PORT_IDX_WIDTH-1:0] sel_hi;
    logic [PORT_IDX_WIDTH-1:0] sel_lo;
    found_hi = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (bus.l2req_valid[p]) begin
        sel_lo = PORT_IDX_WIDTH'(p);
        if (PORT_IDX_WIDTH'(p) >= rr_ptr_q) begin
          sel_hi   = PORT_IDX_WIDTH'(p);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  // Grant outputs and selected-port field mux
  always_comb begin
    bus.l2req_ready = '0;
    core_unit       = '0;
    core_strand     = '0;
    core_op         = '0;
    core_way        = '0;
    core_addr       = '0;
    core_data       = '0;
    core_mask       = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel == PORT_IDX_WIDTH'(p)) begin
        bus.l2req_ready[p] = core_win;
        core_unit          = bus.l2req_unit[2*p +: 2];
        core_strand        = bus.l2req_strand[2*p +: 2];
        core_op            = bus.l2req_op[3*p +: 3];
        core_way           = bus.l2req_way[2*p +: 2];
        core_addr          = bus.l2req_address[ADDR_WIDTH*p +: ADDR_WIDTH];
        core_data          = bus.l2req_data[DATA_WIDTH*p +: DATA_WIDTH];
        core_mask          = bus.l2req_mask[MASK_WIDTH*p +: MASK_WIDTH];
      end
    end
  end

  assign bus.smi_data_accept = smi_win;

  // --------------------------------------------------------------------------
  // Arbitration state next-state
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (core_win) begin
      rr_ptr_d     = (sel == LastPort) ? '0 : sel + 1'b1;
      starve_cnt_d = '0;
    end else if (smi_win && core_ok && (starve_cnt_q != StarveMax)) begin
      // Only count SMI wins that actually kept an eligible core waiting.
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage-1 register. Stall and "no winner" both just drop valid; every other
  // field holds its last value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      port_q     <= '0;
      unit_q     <= '0;
      strand_q   <= '0;
      op_q       <= '0;
      way_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      has_sm_q   <= 1'b0;
      sm_data_q  <= '0;
      fill_way_q <= '0;
    end else begin
      valid_q <= smi_win || core_win;
      if (smi_win) begin
        port_q     <= '0;
        unit_q     <= bus.smi_l2req_unit;
        strand_q   <= bus.smi_l2req_strand;
        op_q       <= bus.smi_l2req_op;
        way_q      <= bus.smi_l2req_way;
        addr_q     <= bus.smi_l2req_address;
        data_q     <= bus.smi_l2req_data;
        mask_q     <= bus.smi_l2req_mask;
        has_sm_q   <= !bus.smi_duplicate_request;
        sm_data_q  <= bus.smi_load_buffer_vec;
        fill_way_q <= bus.smi_fill_l2_way;
      end else if (core_win) begin
        // Fill way is deliberately left untouched on core wins.
        port_q    <= sel;
        unit_q    <= core_unit;
        strand_q  <= core_strand;
        op_q      <= core_op;
        way_q     <= core_way;
        addr_q    <= core_addr;
        data_q    <= core_data;
        mask_q    <= core_mask;
        has_sm_q  <= 1'b0;
        sm_data_q <= '0;
      end
    end
  end

  assign bus.arb_l2req_valid    = valid_q;
  assign bus.arb_l2req_port     = port_q;
  assign bus.arb_l2req_unit     = unit_q;
  assign bus.arb_l2req_strand   = strand_q;
  assign bus.arb_l2req_op       = op_q;
  assign bus.arb_l2req_way      = way_q;
  assign bus.arb_l2req_address  = addr_q;
  assign bus.arb_l2req_data     = data_q;
  assign bus.arb_l2req_mask     = mask_q;
  assign bus.arb_has_sm_data    = has_sm_q;
  assign bus.arb_sm_data        = sm_data_q;
  assign bus.arb_sm_fill_l2_way = fill_way_q;

endmodule

// File: tb/tb_l2_cache_arb_rr.sv
module tb_l2_cache_arb_rr;

  localparam int unsigned NP = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 512;
  localparam int unsigned MW = 64;

  localparam logic [AW-1:0] SmiAddr = 26'h1234567;
  localparam logic [DW-1:0] SmiVec  = {16{32'hDEADBEEF}};
  localparam logic [DW-1:0] SmiData = {16{32'h5A5A0001}};

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  l2_cache_arb_rr_if #(
    .NUM_PORTS(NP), .PORT_IDX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)
  ) bus ();

  l2_cache_arb_rr #(
    .NUM_PORTS(NP), .PORT_IDX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .STARVE_LIMIT(8), .CNT_WIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [AW-1:0] port_addr(int i);
    return 26'h0A0000 + AW'(i);
  endfunction

  function automatic logic [DW-1:0] port_data(int i);
    return {16{32'hC0DE0000 + 32'(i)}};
  endfunction

  task automatic init_fields();
    bus.stall_pipeline        = 1'b0;
    bus.l2req_valid           = '0;
    bus.smi_input_wait        = 1'b0;
    bus.smi_data_ready        = 1'b0;
    bus.smi_l2req_unit        = 2'd3;
    bus.smi_l2req_strand      = 2'd2;
    bus.smi_l2req_op          = 3'd5;
    bus.smi_l2req_way         = 2'd1;
    bus.smi_l2req_address     = SmiAddr;
    bus.smi_l2req_data        = SmiData;
    bus.smi_l2req_mask        = 64'hFFFF_0000_FFFF_0000;
    bus.smi_load_buffer_vec   = SmiVec;
    bus.smi_fill_l2_way       = 2'b10;
    bus.smi_duplicate_request = 1'b0;
    for (int i = 0; i < NP; i++) begin
      bus.l2req_unit[2*i +: 2]      = 2'(i);
      bus.l2req_strand[2*i +: 2]    = 2'(3 - i);
      bus.l2req_op[3*i +: 3]        = 3'(i + 1);
      bus.l2req_way[2*i +: 2]       = 2'(i);
      bus.l2req_address[AW*i +: AW] = port_addr(i);
      bus.l2req_data[DW*i +: DW]    = port_data(i);
      bus.l2req_mask[MW*i +: MW]    = 64'h1 << i;
    end
  endtask

  // Leaves inputs idle and returns 1 time unit after a posedge.
  task automatic do_reset();
    reset                 = 1'b1;
    bus.stall_pipeline    = 1'b0;
    bus.l2req_valid       = '0;
    bus.smi_input_wait    = 1'b0;
    bus.smi_data_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.l2req_valid = 4'b0100;
    @(posedge clk); #1;
    // Reset mid-stream with everything active
    reset              = 1'b1;
    bus.l2req_valid    = 4'b1111;
    bus.smi_data_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.l2req_ready !== 4'b0000 || bus.smi_data_accept !== 1'b0) begin
      $display("FAIL reset_grants: ready=%b accept=%b, want 0000/0",
               bus.l2req_ready, bus.smi_data_accept);
      n_err++;
    end
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    if (bus.arb_l2req_valid !== 1'b0 || bus.arb_l2req_port !== '0 ||
        bus.arb_l2req_address !== '0 || bus.arb_l2req_data !== '0 ||
        bus.arb_has_sm_data !== 1'b0 || bus.arb_sm_data !== '0 ||
        bus.arb_sm_fill_l2_way !== 2'b00 || bus.arb_l2req_op !== 3'd0) begin
      $display("FAIL reset_outputs: valid=%b port=%0d addr=%h has_sm=%b fill=%b, want all 0",
               bus.arb_l2req_valid, bus.arb_l2req_port, bus.arb_l2req_address,
               bus.arb_has_sm_data, bus.arb_sm_fill_l2_way);
      n_err++;
    end
    reset              = 1'b0;
    bus.smi_data_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.l2req_ready !== 4'b0001) begin
      $display("FAIL reset_first_grant: ready=%b, want 0001", bus.l2req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.arb_l2req_valid !== 1'b1 || bus.arb_l2req_port !== 2'd0 ||
        bus.arb_l2req_address !== port_addr(0)) begin
      $display("FAIL reset_first_req: valid=%b port=%0d addr=%h, want 1/0/%h",
               bus.arb_l2req_valid, bus.arb_l2req_port, bus.arb_l2req_address, port_addr(0));
      n_err++;
    end
    bus.l2req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.l2req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int p;
      p = k % NP;
      @(negedge clk);
      n_vec++;
      if (bus.l2req_ready !== (4'b0001 << p) || bus.smi_data_accept !== 1'b0) begin
        $display("FAIL rr_grant%0d: ready=%b accept=%b, want %b/0",
                 k, bus.l2req_ready, bus.smi_data_accept, 4'b0001 << p);
        n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.arb_l2req_valid !== 1'b1 || bus.arb_l2req_port !== IW'(p) ||
          bus.arb_l2req_address !== port_addr(p) || bus.arb_l2req_data !== port_data(p) ||
          bus.arb_l2req_mask !== (64'h1 << p) || bus.arb_l2req_op !== 3'(p + 1)) begin
        $display("FAIL rr_req%0d: valid=%b port=%0d addr=%h op=%0d, want 1/%0d/%h/%0d",
                 k, bus.arb_l2req_valid, bus.arb_l2req_port, bus.arb_l2req_address,
                 bus.arb_l2req_op, p, port_addr(p), p + 1);
        n_err++;
      end
    end
    bus.l2req_valid = '0;
  endtask

  task automatic test_smi_priority();
    do_reset();
    bus.l2req_valid           = 4'b0110;
    bus.smi_data_ready        = 1'b1;
    bus.smi_duplicate_request = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.smi_data_accept !== 1'b1 || bus.l2req_ready !== 4'b0000) begin
      $display("FAIL smi_grant: accept=%b ready=%b, want 1/0000",
               bus.smi_data_accept, bus.l2req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.arb_l2req_valid !== 1'b1 || bus.arb_has_sm_data !== 1'b1 ||
        bus.arb_sm_data !== SmiVec || bus.arb_l2req_address !== SmiAddr ||
        bus.arb_l2req_port !== 2'd0 || bus.arb_sm_fill_l2_way !== 2'b10 ||
        bus.arb_l2req_op !== 3'd5 || bus.arb_l2req_data !== SmiData) begin
      $display("FAIL smi_req: valid=%b has_sm=%b addr=%h port=%0d fill=%b op=%0d, want 1/1/%h/0/10/5",
               bus.arb_l2req_valid, bus.arb_has_sm_data, bus.arb_l2req_address,
               bus.arb_l2req_port, bus.arb_sm_fill_l2_way, bus.arb_l2req_op, SmiAddr);
      n_err++;
    end
    bus.smi_duplicate_request = 1'b1;
    bus.smi_fill_l2_way       = 2'b10;
    @(posedge clk); #1;
    n_vec++;
    if (bus.arb_l2req_valid !== 1'b1 || bus.arb_has_sm_data !== 1'b0) begin
      $display("FAIL smi_dup: valid=%b has_sm=%b, want 1/0",
               bus.arb_l2req_valid, bus.arb_has_sm_data);
      n_err++;
    end
    bus.smi_data_ready        = 1'b0;
    bus.smi_duplicate_request = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.l2req_ready !== 4'b0010 || bus.smi_data_accept !== 1'b0) begin
      $display("FAIL smi_then_core: ready=%b accept=%b, want 0010/0",
               bus.l2req_ready, bus.smi_data_accept);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.arb_l2req_port !== 2'd1 || bus.arb_has_sm_data !== 1'b0 ||
        bus.arb_sm_data !== '0 || bus.arb_sm_fill_l2_way !== 2'b10) begin
      $display("FAIL core_after_smi: port=%0d has_sm=%b fill=%b, want 1/0/10 and sm_data 0",
               bus.arb_l2req_port, bus.arb_has_sm_data, bus.arb_sm_fill_l2_way);
      n_err++;
    end
    bus.l2req_valid = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    bus.smi_data_ready = 1'b1;
    bus.l2req_valid    = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      logic       exp_acc;
      logic [3:0] exp_rdy;
      exp_acc = (k != 8);
      exp_rdy = (k == 8) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      n_vec++;
      if (bus.smi_data_accept !== exp_acc || bus.l2req_ready !== exp_rdy) begin
        $display("FAIL starve_cycle%0d: accept=%b ready=%b, want %b/%b",
                 k, bus.smi_data_accept, bus.l2req_ready, exp_acc, exp_rdy);
        n_err++;
      end
      @(posedge clk); #1;
      if (k == 8) begin
        n_vec++;
        if (bus.arb_l2req_port !== 2'd3 || bus.arb_has_sm_data !== 1'b0 ||
            bus.arb_l2req_address !== port_addr(3)) begin
          $display("FAIL starve_forced_req: port=%0d has_sm=%b addr=%h, want 3/0/%h",
                   bus.arb_l2req_port, bus.arb_has_sm_data, bus.arb_l2req_address, port_addr(3));
          n_err++;
        end
      end
    end
    bus.smi_data_ready = 1'b0;
    bus.l2req_valid    = '0;
  endtask

  task automatic test_queue_full();
    do_reset();
    bus.l2req_valid = 4'b0001;
    @(posedge clk); #1;
    // rr_ptr now 1
    bus.smi_input_wait = 1'b1;
    bus.l2req_valid    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.l2req_ready !== 4'b0000 || bus.smi_data_accept !== 1'b0) begin
        $display("FAIL wait_grant%0d: ready=%b accept=%b, want 0000/0",
                 k, bus.l2req_ready, bus.smi_data_accept);
        n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.arb_l2req_valid !== 1'b0 || bus.arb_l2req_address !== port_addr(0)) begin
        $display("FAIL wait_hold%0d: valid=%b addr=%h, want 0/%h",
                 k, bus.arb_l2req_valid, bus.arb_l2req_address, port_addr(0));
        n_err++;
      end
    end
    // SMI still wins while the queue is full
    bus.smi_data_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.smi_data_accept !== 1'b1 || bus.l2req_ready !== 4'b0000) begin
      $display("FAIL wait_smi: accept=%b ready=%b, want 1/0000",
               bus.smi_data_accept, bus.l2req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    bus.smi_data_ready = 1'b0;
    bus.smi_input_wait = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.l2req_ready !== 4'b0010) begin
      $display("FAIL wait_release: ready=%b, want 0010", bus.l2req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    bus.l2req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    bus.l2req_valid = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Ports 0 and 1 granted; stage-1 holds port 1
    bus.stall_pipeline = 1'b1;
    bus.smi_data_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.l2req_ready !== 4'b0000 || bus.smi_data_accept !== 1'b0) begin
        $display("FAIL stall_grant%0d: ready=%b accept=%b, want 0000/0",
                 k, bus.l2req_ready, bus.smi_data_accept);
        n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (bus.arb_l2req_valid !== 1'b0 || bus.arb_l2req_port !== 2'd1 ||
          bus.arb_l2req_address !== port_addr(1) || bus.arb_l2req_data !== port_data(1)) begin
        $display("FAIL stall_hold%0d: valid=%b port=%0d addr=%h, want 0/1/%h",
                 k, bus.arb_l2req_valid, bus.arb_l2req_port, bus.arb_l2req_address,
                 port_addr(1));
        n_err++;
      end
    end
    bus.stall_pipeline = 1'b0;
    bus.smi_data_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.l2req_ready !== 4'b0100) begin
      $display("FAIL stall_resume: ready=%b, want 0100", bus.l2req_ready);
      n_err++;
    end
    @(posedge clk); #1;
    bus.l2req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    init_fields();
    test_reset();
    test_round_robin();
    test_smi_priority();
    test_starvation();
    test_queue_full();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_cache_arb_rr.md
Name: l2_cache_arb_rr

Overview:
- Parametrised next-generation L2 pipeline arbitration stage.
- Selects, once per cycle, either the restarted request from the system memory interface (SMI) queue, or one of NUM_PORTS core request ports. Core ports are chosen by round-robin.
- Registers the winner into the first L2 pipeline stage.
- Adds per-port ready, an explicit SMI accept, and a bounded-starvation override so that sustained SMI restarts cannot lock out cores indefinitely.

Parameters:
- NUM_PORTS, 4, number of core request ports (2..16)
- PORT_IDX_WIDTH, 2, width of a port index; 2**PORT_IDX_WIDTH >= NUM_PORTS
- ADDR_WIDTH, 26, cache-line address width
- DATA_WIDTH, 512, line data width
- MASK_WIDTH, 64, byte mask width (DATA_WIDTH/8)
- STARVE_LIMIT, 8, consecutive SMI wins before one core slot is forced; 0 disables the override
- CNT_WIDTH, 4, starvation counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_pipeline  in  1  downstream stall
- l2req_valid  in  NUM_PORTS  per-port request valid
- l2req_ready  out  NUM_PORTS  one-hot grant, combinational
- l2req_unit  in  2*NUM_PORTS  packed per port; port i occupies bits [2i+1:2i]
- l2req_strand  in  2*NUM_PORTS  packed per port
- l2req_op  in  3*NUM_PORTS  packed per port
- l2req_way  in  2*NUM_PORTS  packed per port
- l2req_address  in  ADDR_WIDTH*NUM_PORTS  packed per port
- l2req_data  in  DATA_WIDTH*NUM_PORTS  packed per port
- l2req_mask  in  MASK_WIDTH*NUM_PORTS  packed per port
- smi_input_wait  in  1  SMI queue full; no core request may be accepted
- smi_data_ready  in  1  restart request pending
- smi_data_accept  out  1  restart consumed this cycle, combinational
- smi_l2req_unit / strand / op / way / address / data / mask  in  2/2/3/2/ADDR_WIDTH/DATA_WIDTH/MASK_WIDTH  restart request fields
- smi_load_buffer_vec  in  DATA_WIDTH  fill data
- smi_fill_l2_way  in  2  fill way
- smi_duplicate_request  in  1  fill already present
- arb_l2req_valid  out  1  registered request valid
- arb_l2req_port  out  PORT_IDX_WIDTH  source port index; 0 for SMI wins
- arb_l2req_unit / strand / op / way / address / data / mask  out  as inputs  registered request fields
- arb_has_sm_data  out  1  registered fill-data flag
- arb_sm_data  out  DATA_WIDTH  registered fill data
- arb_sm_fill_l2_way  out  2  registered fill way

Behaviour:
- Reset: every output register is cleared to 0; rr_ptr = 0; starve_cnt = 0. Reset has priority over stall.
- Core eligibility: core_ok = !stall_pipeline && !smi_input_wait && |l2req_valid.
- Starvation override: force = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
- Decision (combinational):
  - SMI wins when !stall_pipeline && smi_data_ready && !(force && core_ok).
  - Otherwise a core wins when core_ok.
  - Otherwise there is no winner.
- Round-robin search: the first valid port at or after rr_ptr, modulo NUM_PORTS.
- smi_data_accept = SMI win. l2req_ready[i] = core win and selected port == i. At most one of these is high in any cycle.
- Registered stage (1-cycle latency):
  - SMI win: load smi_* fields; arb_l2req_valid = 1; arb_has_sm_data = !smi_duplicate_request; arb_sm_data = smi_load_buffer_vec; arb_sm_fill_l2_way = smi_fill_l2_way; arb_l2req_port = 0.
  - Core win: load the selected port's fields; arb_l2req_valid = 1; arb_l2req_port = index; arb_has_sm_data = 0; arb_sm_data = 0; arb_sm_fill_l2_way holds.
  - No winner: arb_l2req_valid = 0; all other outputs hold.
  - stall_pipeline: arb_l2req_valid = 0; all other outputs, rr_ptr and starve_cnt hold; all readies and smi_data_accept are 0.
- rr_ptr update: on a core grant to port p, rr_ptr = (p+1) mod NUM_PORTS; wrap from NUM_PORTS-1 goes to 0. Otherwise rr_ptr is unchanged.
- starve_cnt update:
  - Increments (saturating at STARVE_LIMIT) on an SMI win while core_ok would have been true.
  - Clears on any core grant.
  - Holds otherwise.
  - Forced core slot: smi_data_ready stays high and SMI holds its request, since no accept is given.
- smi_input_wait with smi_data_ready: the SMI still wins. The override never applies, because core_ok = 0.
- Reset mid-stream: any in-flight register contents are discarded and the valid output is cleared.

Test Plan:
- Reset: assert reset for 2 cycles with all inputs active -> all outputs 0, all l2req_ready = 0, smi_data_accept = 0; first request after release is granted to port 0.
- Round-robin: all 4 ports valid continuously, no SMI -> grants 0,1,2,3,0 on consecutive cycles; arb_l2req_port follows one cycle later with the matching address of each port.
- SMI priority: smi_data_ready = 1 with smi_duplicate_request = 0, ports 1 and 2 valid -> smi_data_accept = 1, no ready; next cycle arb_has_sm_data = 1, arb_sm_data = smi_load_buffer_vec.
- Starvation: STARVE_LIMIT = 8, SMI and port 3 valid continuously -> 8 SMI grants, then l2req_ready[3] = 1 on the 9th cycle with smi_data_accept = 0, then SMI grants resume.
- Queue full: smi_input_wait = 1, ports valid, no SMI -> no ready for 5 cycles, arb_l2req_valid = 0, rr_ptr unchanged; on release the port at the old rr_ptr wins.
- Stall: stall_pipeline = 1 for 3 cycles during traffic -> arb_l2req_valid = 0, data outputs hold, no accepts; after release the round-robin order continues without skipping a port.
